// File: rtl/ysyx_22050598_csr_trap_ctrl_if.sv
// CSR file access bus: one combinational read port and one write port.
// The controller drives index/enable/data (master); the CSR file answers
// with read data (slave).
interface ysyx_22050598_csr_trap_ctrl_if #(
  parameter int DATA_W = 64
);
  logic [1:0]        read_csr_idx;
  logic [DATA_W-1:0] read_csr_data;
  logic              write_en;
  logic [1:0]        write_csr_idx;
  logic [DATA_W-1:0] write_csr_data;

  modport master (
    output read_csr_idx, write_en, write_csr_idx, write_csr_data,
    input  read_csr_data
  );

  modport slave (
    input  read_csr_idx, write_en, write_csr_idx, write_csr_data,
    output read_csr_data
  );
endinterface

// File: rtl/ysyx_22050598_csr_trap_ctrl.sv
// CSR trap controller: arbitrates the single-write-port machine CSR file
// between CSR instructions and the multi-step ecall / mret sequences, and
// issues a one-cycle PC redirect at the end of each sequence.
// CSR indices: 0=mstatus, 1=mtvec, 2=mepc, 3=mcause.
module ysyx_22050598_csr_trap_ctrl #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trap_req_i,
  input  logic [DATA_W-1:0] trap_pc_i,
  input  logic [DATA_W-1:0] trap_cause_i,
  output logic              trap_ack_o,
  input  logic              mret_req_i,
  output logic              mret_ack_o,
  input  logic              csr_op_valid_i,
  input  logic [1:0]        csr_op_i,
  input  logic [1:0]        csr_op_idx_i,
  input  logic [DATA_W-1:0] csr_op_wdata_i,
  output logic              csr_op_ready_o,
  output logic [DATA_W-1:0] csr_op_rdata_o,
  output logic              redirect_valid_o,
  output logic [DATA_W-1:0] redirect_pc_o,
  output logic              busy_o,
  ysyx_22050598_csr_trap_ctrl_if.master csr_if
);

  localparam logic [1:0] IDX_MSTATUS = 2'd0;
  localparam logic [1:0] IDX_MTVEC   = 2'd1;
  localparam logic [1:0] IDX_MEPC    = 2'd2;
  localparam logic [1:0] IDX_MCAUSE  = 2'd3;

  typedef enum logic [2:0] {
    IDLE, T_EPC, T_CAUSE, T_STAT, T_JUMP, M_STAT, M_JUMP
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] cause_q, cause_d;
  logic [DATA_W-1:0] redirect_pc_q;
  logic [DATA_W-1:0] old;

  assign old    = csr_if.read_csr_data;
  assign busy_o = (state_q != IDLE);

  // Arbitration, per-state CSR access and redirect generation. Outputs are
  // forced to zero while reset is asserted so an aborted sequence can issue
  // neither a write nor a redirect in the reset cycle.
  always_comb begin
    trap_ack_o            = 1'b0;
    mret_ack_o            = 1'b0;
    csr_op_ready_o        = 1'b0;
    csr_op_rdata_o        = '0;
    csr_if.read_csr_idx   = IDX_MSTATUS;
    csr_if.write_en       = 1'b0;
    csr_if.write_csr_idx  = IDX_MSTATUS;
    csr_if.write_csr_data = '0;
    redirect_valid_o      = 1'b0;
    redirect_pc_o         = redirect_pc_q;
    state_d               = state_q;
    pc_d                  = pc_q;
    cause_d               = cause_q;
    case (state_q)
      IDLE: begin
        csr_if.read_csr_idx = csr_op_idx_i;
        if (trap_req_i) begin
          trap_ack_o = 1'b1;
          pc_d       = trap_pc_i;
          cause_d    = trap_cause_i;
          state_d    = T_EPC;
        end else if (mret_req_i) begin
          mret_ack_o = 1'b1;
          state_d    = M_STAT;
        end else if (csr_op_valid_i) begin
          csr_op_ready_o       = 1'b1;
          csr_op_rdata_o       = old;
          csr_if.write_csr_idx = csr_op_idx_i;
          case (csr_op_i)
            2'b01: begin
              csr_if.write_en       = 1'b1;
              csr_if.write_csr_data = csr_op_wdata_i;
            end
            2'b10: begin
              // set/clear with a zero mask must not write (side-effect free)
              csr_if.write_en       = |csr_op_wdata_i;
              csr_if.write_csr_data = old | csr_op_wdata_i;
            end
            2'b11: begin
              csr_if.write_en       = |csr_op_wdata_i;
              csr_if.write_csr_data = old & ~csr_op_wdata_i;
            end
            default: ;
          endcase
        end
      end
      T_EPC: begin
        csr_if.write_en       = 1'b1;
        csr_if.write_csr_idx  = IDX_MEPC;
        csr_if.write_csr_data = pc_q;
        state_d               = T_CAUSE;
      end
      T_CAUSE: begin
        csr_if.write_en       = 1'b1;
        csr_if.write_csr_idx  = IDX_MCAUSE;
        csr_if.write_csr_data = cause_q;
        state_d               = T_STAT;
      end
      T_STAT: begin
        // MPIE <= MIE, MIE <= 0, MPP <= M
        csr_if.read_csr_idx          = IDX_MSTATUS;
        csr_if.write_en              = 1'b1;
        csr_if.write_csr_idx         = IDX_MSTATUS;
        csr_if.write_csr_data        = old;
        csr_if.write_csr_data[7]     = old[3];
        csr_if.write_csr_data[3]     = 1'b0;
        csr_if.write_csr_data[12:11] = 2'b11;
        state_d                      = T_JUMP;
      end
      T_JUMP: begin
        // direct mode only: mode bits of mtvec are dropped
        csr_if.read_csr_idx = IDX_MTVEC;
        redirect_valid_o    = 1'b1;
        redirect_pc_o       = {old[DATA_W-1:2], 2'b00};
        state_d             = IDLE;
      end
      M_STAT: begin
        // MIE <= MPIE, MPIE <= 1, MPP <= M
        csr_if.read_csr_idx          = IDX_MSTATUS;
        csr_if.write_en              = 1'b1;
        csr_if.write_csr_idx         = IDX_MSTATUS;
        csr_if.write_csr_data        = old;
        csr_if.write_csr_data[3]     = old[7];
        csr_if.write_csr_data[7]     = 1'b1;
        csr_if.write_csr_data[12:11] = 2'b11;
        state_d                      = M_JUMP;
      end
      M_JUMP: begin
        csr_if.read_csr_idx = IDX_MEPC;
        redirect_valid_o    = 1'b1;
        redirect_pc_o       = old;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      trap_ack_o       = 1'b0;
      mret_ack_o       = 1'b0;
      csr_op_ready_o   = 1'b0;
      csr_op_rdata_o   = '0;
      csr_if.write_en  = 1'b0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
    end
  end

  // State, latched trap info and the held redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      cause_q       <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      cause_q       <= cause_d;
      redirect_pc_q <= redirect_pc_o;
    end
  end

endmodule

// File: tb/tb_ysyx_22050598_csr_trap_ctrl.sv
// Bench for the CSR trap controller: a table of CSR instruction vectors
// against a small CSR file model, then hand-written trap / mret / priority /
// reset-abort sequences.
module tb_ysyx_22050598_csr_trap_ctrl;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              trap_req, mret_req, csr_op_valid;
  logic [DATA_W-1:0] trap_pc, trap_cause, csr_op_wdata;
  logic [1:0]        csr_op, csr_op_idx;
  logic              trap_ack, mret_ack, csr_op_ready, redirect_valid, busy;
  logic [DATA_W-1:0] csr_op_rdata, redirect_pc;
  logic              csrf_rst;
  logic [DATA_W-1:0] csrf [4];
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  ysyx_22050598_csr_trap_ctrl_if #(.DATA_W(DATA_W)) csr_if ();

  ysyx_22050598_csr_trap_ctrl #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .trap_req_i(trap_req), .trap_pc_i(trap_pc), .trap_cause_i(trap_cause),
    .trap_ack_o(trap_ack), .mret_req_i(mret_req), .mret_ack_o(mret_ack),
    .csr_op_valid_i(csr_op_valid), .csr_op_i(csr_op), .csr_op_idx_i(csr_op_idx),
    .csr_op_wdata_i(csr_op_wdata), .csr_op_ready_o(csr_op_ready),
    .csr_op_rdata_o(csr_op_rdata), .redirect_valid_o(redirect_valid),
    .redirect_pc_o(redirect_pc), .busy_o(busy), .csr_if(csr_if.master)
  );

  // CSR file model: combinational read, write at the clock edge
  assign csr_if.read_csr_data = csrf[csr_if.read_csr_idx];
  always @(posedge clk) begin
    if (csrf_rst) begin
      for (int i = 0; i < 4; i++) csrf[i] <= '0;
    end else if (csr_if.write_en) begin
      csrf[csr_if.write_csr_idx] <= csr_if.write_csr_data;
    end
  end

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    trap_req = 0; mret_req = 0; csr_op_valid = 0;
    trap_pc = '0; trap_cause = '0; csr_op = 0; csr_op_idx = 0; csr_op_wdata = '0;
  endtask

  typedef struct {
    logic [1:0]        op;
    logic [1:0]        idx;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] exp_rd;
    logic              exp_we;
    logic [DATA_W-1:0] exp_wd;
  } vec_t;

  vec_t vt [12];
  int   nbusy;

  initial begin
    vt[0]  = '{2'b01, 2'd1, 64'h8000_0000, 64'h0,         1'b1, 64'h8000_0000};
    vt[1]  = '{2'b00, 2'd1, 64'h1234,      64'h8000_0000, 1'b0, 64'h0};
    vt[2]  = '{2'b01, 2'd0, 64'h88,        64'h0,         1'b1, 64'h88};
    vt[3]  = '{2'b10, 2'd0, 64'h0,         64'h88,        1'b0, 64'h0};
    vt[4]  = '{2'b11, 2'd0, 64'h8,         64'h88,        1'b1, 64'h80};
    vt[5]  = '{2'b10, 2'd0, 64'h8,         64'h80,        1'b1, 64'h88};
    vt[6]  = '{2'b01, 2'd3, 64'h5,         64'h0,         1'b1, 64'h5};
    vt[7]  = '{2'b11, 2'd3, 64'h0,         64'h5,         1'b0, 64'h0};
    vt[8]  = '{2'b10, 2'd2, 64'hF0,        64'h0,         1'b1, 64'hF0};
    vt[9]  = '{2'b11, 2'd2, 64'h30,        64'hF0,        1'b1, 64'hC0};
    vt[10] = '{2'b01, 2'd1, 64'h8000_0103, 64'h8000_0000, 1'b1, 64'h8000_0103};
    vt[11] = '{2'b01, 2'd0, 64'h8,         64'h88,        1'b1, 64'h8};

    idle_inputs();
    rst = 1; csrf_rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst busy", busy, 0);
    chk("rst write_en", csr_if.write_en, 0);
    chk("rst redirect_valid", redirect_valid, 0);
    chk("rst redirect_pc", redirect_pc, 0);
    chk("rst trap_ack", trap_ack, 0);
    chk("rst csr_op_ready", csr_op_ready, 0);
    @(posedge clk);
    @(negedge clk); rst = 0; csrf_rst = 0;

    // CSR instruction table
    for (int i = 0; i < 12; i++) begin
      if (i != 0) @(negedge clk);
      csr_op_valid = 1; csr_op = vt[i].op; csr_op_idx = vt[i].idx; csr_op_wdata = vt[i].wd;
      #1;
      chk($sformatf("v%0d ready", i), csr_op_ready, 1);
      chk($sformatf("v%0d rdata", i), csr_op_rdata, vt[i].exp_rd);
      chk($sformatf("v%0d write_en", i), csr_if.write_en, vt[i].exp_we);
      if (vt[i].exp_we) begin
        chk($sformatf("v%0d widx", i), csr_if.write_csr_idx, vt[i].idx);
        chk($sformatf("v%0d wdata", i), csr_if.write_csr_data, vt[i].exp_wd);
      end
    end
    @(negedge clk); idle_inputs(); #1;
    chk("csrf mstatus", csrf[0], 64'h8);
    chk("csrf mtvec", csrf[1], 64'h8000_0103);
    chk("idle ready", csr_op_ready, 0);

    // Trap entry
    trap_req = 1; trap_pc = 64'h8000_0040; trap_cause = 64'd11; #1;
    chk("trap ack", trap_ack, 1);
    chk("trap busy c0", busy, 0);
    @(negedge clk); idle_inputs(); #1;
    chk("T_EPC busy", busy, 1);
    chk("T_EPC we", csr_if.write_en, 1);
    chk("T_EPC idx", csr_if.write_csr_idx, 2);
    chk("T_EPC data", csr_if.write_csr_data, 64'h8000_0040);
    chk("T_EPC ack", trap_ack, 0);
    @(negedge clk); #1;
    chk("T_CAUSE idx", csr_if.write_csr_idx, 3);
    chk("T_CAUSE data", csr_if.write_csr_data, 64'd11);
    chk("T_CAUSE redir", redirect_valid, 0);
    @(negedge clk); #1;
    chk("T_STAT idx", csr_if.write_csr_idx, 0);
    chk("T_STAT data", csr_if.write_csr_data, 64'h1880);
    @(negedge clk); #1;
    chk("T_JUMP redir", redirect_valid, 1);
    chk("T_JUMP pc", redirect_pc, 64'h8000_0100);
    chk("T_JUMP we", csr_if.write_en, 0);
    @(negedge clk); #1;
    chk("trap done busy", busy, 0);
    chk("trap done redir", redirect_valid, 0);
    chk("trap hold pc", redirect_pc, 64'h8000_0100);
    chk("mepc", csrf[2], 64'h8000_0040);
    chk("mcause", csrf[3], 64'd11);
    chk("mstatus trap", csrf[0], 64'h1880);

    // Mret
    mret_req = 1; #1;
    chk("mret ack", mret_ack, 1);
    @(negedge clk); idle_inputs(); #1;
    chk("M_STAT data", csr_if.write_csr_data, 64'h1888);
    chk("M_STAT redir", redirect_valid, 0);
    @(negedge clk); #1;
    chk("M_JUMP redir", redirect_valid, 1);
    chk("M_JUMP pc", redirect_pc, 64'h8000_0040);
    chk("M_JUMP we", csr_if.write_en, 0);
    @(negedge clk); #1;
    chk("mret done busy", busy, 0);
    chk("mstatus mret", csrf[0], 64'h1888);

    // All requests at once: trap wins, mret waits for the first IDLE cycle
    trap_req = 1; trap_pc = 64'h8000_0200; trap_cause = 64'd11;
    mret_req = 1; csr_op_valid = 1; csr_op = 2'b01; csr_op_idx = 2'd3; csr_op_wdata = 64'hDEAD;
    #1;
    chk("prio trap_ack", trap_ack, 1);
    chk("prio mret_ack", mret_ack, 0);
    chk("prio ready", csr_op_ready, 0);
    @(negedge clk); trap_req = 0; #1;
    nbusy = 0;
    for (int c = 0; c < 10 && busy; c++) begin
      nbusy++;
      chk("busy ready", csr_op_ready, 0);
      chk("busy mret_ack", mret_ack, 0);
      @(negedge clk); #1;
    end
    chk("prio busy cycles", nbusy, 4);
    chk("prio mret after", mret_ack, 1);
    chk("prio ready after", csr_op_ready, 0);
    @(negedge clk); idle_inputs(); #1;
    chk("prio M_STAT data", csr_if.write_csr_data, 64'h1888);
    @(negedge clk); #1;
    chk("prio M_JUMP pc", redirect_pc, 64'h8000_0200);
    @(negedge clk); #1;
    chk("prio mcause kept", csrf[3], 64'd11);

    // Reset in T_CAUSE aborts the trap
    trap_req = 1; trap_pc = 64'h8000_0300; trap_cause = 64'd7; #1;
    chk("abort ack", trap_ack, 1);
    @(negedge clk); idle_inputs(); #1;
    chk("abort T_EPC data", csr_if.write_csr_data, 64'h8000_0300);
    @(negedge clk); rst = 1; #1;
    chk("abort rst we", csr_if.write_en, 0);
    @(negedge clk); rst = 0; #1;
    chk("abort busy", busy, 0);
    chk("abort redir", redirect_valid, 0);
    chk("abort we", csr_if.write_en, 0);
    chk("abort redirect_pc", redirect_pc, 0);
    begin
      int nredir = 0;
      repeat (6) begin
        @(negedge clk); #1;
        if (redirect_valid || csr_if.write_en) nredir++;
      end
      chk("abort no activity", nredir, 0);
    end
    chk("abort mepc", csrf[2], 64'h8000_0300);
    chk("abort mcause", csrf[3], 64'd11);
    chk("abort mstatus", csrf[0], 64'h1888);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/ysyx_22050598_csr_trap_ctrl.md
Name: ysyx_22050598_csr_trap_ctrl

Overview:
Sequencer and arbiter for the 4-entry single-write-port machine CSR file. It shares the CSR file between two sources:
- CSR instructions (csrrw/csrrs/csrrc) from the execute stage.
- Trap entry (ecall) and mret, which need several CSR reads and writes.

Trap entry and mret are serialised into one CSR access per cycle, and the block emits a one-cycle PC redirect to the fetch stage.

Parameters:
DATA_W, 64, CSR/PC data width.
CSR idx map (fixed): 0=mstatus, 1=mtvec, 2=mepc, 3=mcause.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
trap_req  in  1  ecall request; requester holds it until trap_ack.
trap_pc  in  DATA_W  PC of trapping instruction.
trap_cause  in  DATA_W  mcause value.
trap_ack  out  1  one-cycle pulse: trap accepted, trap_pc and trap_cause latched.
mret_req  in  1  mret request; requester holds it until mret_ack.
mret_ack  out  1  one-cycle pulse: mret accepted.
csr_op_valid  in  1  CSR instruction access request.
csr_op  in  2  00=read only, 01=RW, 10=RS, 11=RC.
csr_op_idx  in  2  target CSR.
csr_op_wdata  in  DATA_W  rs1/imm operand.
csr_op_ready  out  1  access performed this cycle.
csr_op_rdata  out  DATA_W  old CSR value, valid when csr_op_ready=1.
redirect_valid  out  1  one-cycle PC redirect pulse.
redirect_pc  out  DATA_W  redirect target.
busy  out  1  state != IDLE.
read_csr_idx  out  2  CSR file read index.
read_csr_data  in  DATA_W  CSR file read data (combinational).
write_en  out  1  CSR file write enable.
write_csr_idx  out  2  CSR file write index.
write_csr_data  out  DATA_W  CSR file write data.

Behaviour:
- States: IDLE, T_EPC, T_CAUSE, T_STAT, T_JUMP, M_STAT, M_JUMP.
- Reset:
  - State=IDLE.
  - All outputs 0: write_en, acks, csr_op_ready, redirect_valid, redirect_pc, busy, csr_op_rdata.
  - Latched pc and cause = 0.
  - Reset asserted mid-sequence aborts it: no further CSR writes, no redirect.
- IDLE arbitration, fixed priority: trap_req > mret_req > csr_op_valid. Requests are sampled only in IDLE.
  - trap_req=1: trap_ack=1, latch trap_pc and trap_cause, next state T_EPC.
  - else mret_req=1: mret_ack=1, next state M_STAT.
  - else csr_op_valid=1: csr_op_ready=1 combinationally, single cycle.
    - read_csr_idx=csr_op_idx; csr_op_rdata=read_csr_data.
    - New value: RW=wdata, RS=old|wdata, RC=old&~wdata.
    - write_en=1 with write_csr_idx=csr_op_idx, except: op 00 → no write; RS/RC with wdata==0 → no write.
    - Write lands at the next edge.
- csr_op_ready=0 whenever a trap or mret is accepted in the same cycle, and in all non-IDLE states.
- Trap sequence (one CSR write per state):
  - T_EPC: write mepc = latched pc.
  - T_CAUSE: write mcause = latched cause.
  - T_STAT: read mstatus (S); write mstatus with MPIE(bit7)=S[3], MIE(bit3)=0, MPP(12:11)=2'b11, other bits unchanged.
  - T_JUMP: read mtvec; redirect_valid=1, redirect_pc = mtvec with bits[1:0] cleared; next state IDLE.
  - Redirect occurs 4 cycles after the trap_ack cycle.
- Mret sequence:
  - M_STAT: read mstatus (S); write MIE=S[7], MPIE=1, MPP=2'b11.
  - M_JUMP: read mepc; redirect_valid=1, redirect_pc=mepc; next state IDLE.
  - Redirect occurs 2 cycles after mret_ack.
- write_en=0 in T_JUMP and M_JUMP.
- redirect_valid is high only in T_JUMP and M_JUMP. redirect_pc holds its last value otherwise.
- read_csr_idx defaults to csr_op_idx in IDLE and to 0 in states that do not read.
- Back-to-back: a new request can be accepted in the first IDLE cycle after T_JUMP or M_JUMP.

Test Plan:
- Reset, then RW idx1 wdata=0x8000_0000 → ready=1, rdata=0, write_en=1 idx1; next cycle read idx1 = 0x8000_0000.
- RS idx0 wdata=0 with mstatus=0x88 → rdata=0x88, write_en=0, mstatus unchanged. RC idx0 wdata=0x8 → mstatus=0x80.
- mtvec=0x8000_0103, mstatus=0x8, trap_req pc=0x8000_0040 cause=11 →
  - trap_ack at cycle 0.
  - mepc=0x8000_0040 and mcause=11 written in cycles 1-2.
  - mstatus=0x1880.
  - redirect at cycle 4, pc=0x8000_0100.
- Continuing from the trap state, mret_req → mret_ack; mstatus=0x1888; redirect at +2, pc=0x8000_0040.
- trap_req, mret_req and csr_op_valid all high in IDLE → only trap_ack; csr_op_ready=0 until busy drops; mret accepted on the first IDLE cycle afterwards.
- rst asserted in T_CAUSE → next cycle IDLE, busy=0, no mcause/mstatus write, no redirect. mepc keeps the value written in T_EPC.
